// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Receives 8N1 serial frames (start 0, 8 data bits LSB first, stop 1, no
// parity) from an asynchronous line and presents each good byte in parallel.
//
// Ports:
//   sys_clk       in   system clock, all logic on the rising edge
//   sys_rst_n     in   synchronous active-low reset
//   uart_rxd      in   asynchronous serial line, idle high
//   uart_rx_done  out  one-cycle strobe: a new valid byte is on uart_rx_data
//   uart_rx_data  out  last correctly received byte, held until the next one
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int BPS     = 115200,
    parameter int CLK_FRE = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic       uart_rx_done,
    output logic [7:0] uart_rx_data
);

    localparam int BAUD_CNT = CLK_FRE / BPS;
    localparam int HALF_CNT = BAUD_CNT / 2;
    localparam int CNT_W    = $clog2(BAUD_CNT + 1);

    localparam logic [CNT_W-1:0] HALF_VAL = CNT_W'(HALF_CNT);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(BAUD_CNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             rxd_s1;
    logic             rxd_s2;
    logic             rxd_d;
    logic             start_edge;

    logic [CNT_W-1:0] baud_cnt;
    logic             mid_bit;
    logic             bit_end;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             rx_good;

    // Two flops bring the line into the clock domain; the third flop keeps the
    // previous synchronized level so a falling edge can be seen.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    assign start_edge = rxd_d & ~rxd_s2;
    assign mid_bit    = (baud_cnt == HALF_VAL);
    assign bit_end    = (baud_cnt == LAST_VAL);

    // A byte is accepted only when the stop bit reads high at its midpoint.
    assign rx_good    = (state == STOP) && mid_bit && rxd_s2;

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. STOP leaves at its midpoint rather than at its end so
    // that a start bit following immediately after the stop bit is not missed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_next = START;
                end
            end
            START: begin
                if (mid_bit && rxd_s2) begin
                    state_next = IDLE;
                end else if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (mid_bit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit-period counter. Held at zero in IDLE so that START always begins
    // from a fresh count aligned to the detected edge.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            baud_cnt <= '0;
        end else if (state == IDLE || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

    // Data-bit index: cleared as START hands over to DATA, advanced at the end
    // of every data bit.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bit_idx <= 3'd0;
        end else if (state == START && bit_end) begin
            bit_idx <= 3'd0;
        end else if (state == DATA && bit_end) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // Mid-bit samples enter at the MSB and move right, so after eight bits the
    // first (least significant) bit received sits in bit 0.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            shift_reg <= 8'h00;
        end else if (state == DATA && mid_bit) begin
            shift_reg <= {rxd_s2, shift_reg[7:1]};
        end
    end

    // Output byte and strobe update on the same edge so the data is valid in
    // the strobe cycle; a framing error leaves the previous byte in place.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            uart_rx_done <= 1'b0;
            uart_rx_data <= 8'h00;
        end else begin
            uart_rx_done <= rx_good;
            if (rx_good) begin
                uart_rx_data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed self-checking bench for uart_rx at 230400 baud with a 50 MHz clock
// (217 clocks = 4340 ns per bit). Frames are driven on the line with fixed
// delays; a monitor logs every strobe and the byte present in that cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int  CLK_HALF = 10;
    localparam int  BIT_NS   = 4340;
    // Start edge to strobe: 3 + 9*217 + 108 clocks = 2064 clocks.
    localparam longint LAT_NS = 2064 * 20;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       uart_rxd;
    logic       uart_rx_done;
    logic [7:0] uart_rx_data;

    int         checkCount;
    int         failCount;
    int         doneCount;
    int         widthErr;
    logic       prevDone;
    longint     lastDoneTime;
    logic [7:0] rxQueue[$];

    uart_rx #(
        .BPS     (230400),
        .CLK_FRE (50_000_000)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .uart_rxd     (uart_rxd),
        .uart_rx_done (uart_rx_done),
        .uart_rx_data (uart_rx_data)
    );

    // Free-running 50 MHz clock.
    initial begin
        sys_clk = 1'b0;
        forever #CLK_HALF sys_clk = ~sys_clk;
    end

    // Strobe monitor, sampled on the falling edge away from the active edge.
    initial begin
        doneCount    = 0;
        widthErr     = 0;
        prevDone     = 1'b0;
        lastDoneTime = 0;
        forever begin
            @(negedge sys_clk);
            if (uart_rx_done === 1'b1) begin
                doneCount++;
                lastDoneTime = $time;
                rxQueue.push_back(uart_rx_data);
                if (prevDone === 1'b1) begin
                    widthErr++;
                end
            end
            prevDone = uart_rx_done;
        end
    end

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input longint observed,
                               input longint expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Pop the byte logged at the next strobe and compare it.
    task automatic expectByte(input string tag, input logic [7:0] expected);
        checkOutput({tag, "_pulse"}, longint'(rxQueue.size() > 0), 1);
        if (rxQueue.size() > 0) begin
            checkOutput({tag, "_data"}, longint'(rxQueue.pop_front()), longint'(expected));
        end
    endtask

    // Drive one full 8N1 frame; stopVal lets a framing error be injected.
    task automatic applyStimulus(input logic [7:0] b, input logic stopVal);
        uart_rxd = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            #BIT_NS;
        end
        uart_rxd = stopVal;
        #BIT_NS;
    endtask

    initial begin
        int     base;
        longint startTime;

        checkCount = 0;
        failCount  = 0;
        uart_rxd   = 1'b1;
        sys_rst_n  = 1'b0;

        // Reset for one rising edge, line idle.
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checkOutput("rst_done", longint'(uart_rx_done), 0);
        checkOutput("rst_data", longint'(uart_rx_data), 8'h00);
        #3000;
        checkOutput("idle_no_pulse", doneCount, 0);

        // Single frame, latency and hold.
        @(negedge sys_clk);
        startTime = $time;
        applyStimulus(8'h24, 1'b1);
        #BIT_NS;
        checkOutput("single_count", doneCount, 1);
        expectByte("single", 8'h24);
        checkOutput("single_latency_ok",
                    longint'((lastDoneTime - startTime >= LAT_NS - 100) &&
                             (lastDoneTime - startTime <= LAT_NS + 100)), 1);
        #(2 * BIT_NS);
        checkOutput("single_hold", longint'(uart_rx_data), 8'h24);

        // Four frames back to back with no idle gap.
        base = doneCount;
        applyStimulus(8'h81, 1'b1);
        applyStimulus(8'h09, 1'b1);
        applyStimulus(8'h63, 1'b1);
        applyStimulus(8'h0D, 1'b1);
        #BIT_NS;
        checkOutput("b2b_count", doneCount - base, 4);
        expectByte("b2b0", 8'h81);
        expectByte("b2b1", 8'h09);
        expectByte("b2b2", 8'h63);
        expectByte("b2b3", 8'h0D);

        // Short low glitch must be rejected at the start-bit midpoint.
        base = doneCount;
        uart_rxd = 1'b0;
        #1000;
        uart_rxd = 1'b1;
        #(2 * BIT_NS);
        checkOutput("glitch_no_pulse", doneCount - base, 0);
        checkOutput("glitch_data", longint'(uart_rx_data), 8'h0D);
        applyStimulus(8'hA5, 1'b1);
        #BIT_NS;
        checkOutput("after_glitch_count", doneCount - base, 1);
        expectByte("after_glitch", 8'hA5);

        // Framing error: stop bit low, byte dropped.
        base = doneCount;
        applyStimulus(8'h55, 1'b0);
        uart_rxd = 1'b1;
        #(2 * BIT_NS);
        checkOutput("frame_err_no_pulse", doneCount - base, 0);
        checkOutput("frame_err_data", longint'(uart_rx_data), 8'hA5);
        applyStimulus(8'h3C, 1'b1);
        #BIT_NS;
        checkOutput("after_ferr_count", doneCount - base, 1);
        expectByte("after_ferr", 8'h3C);

        // Reset in the middle of data bit 4 of an 8'hFF frame.
        base = doneCount;
        uart_rxd = 1'b0;
        #BIT_NS;
        uart_rxd = 1'b1;
        #(4 * BIT_NS + BIT_NS / 2);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        checkOutput("midrst_data", longint'(uart_rx_data), 8'h00);
        checkOutput("midrst_done", longint'(uart_rx_done), 0);
        sys_rst_n = 1'b1;
        #(5 * BIT_NS);
        checkOutput("midrst_no_pulse", doneCount - base, 0);
        checkOutput("midrst_data_hold", longint'(uart_rx_data), 8'h00);
        applyStimulus(8'h12, 1'b1);
        #BIT_NS;
        checkOutput("after_rst_count", doneCount - base, 1);
        expectByte("after_rst", 8'h12);

        checkOutput("pulse_width_one", widthErr, 0);
        checkOutput("queue_drained", rxQueue.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checkCount, failCount);
        $finish;
    end

endmodule
